id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 104 ++++++++++
 tb/tb_id_ex_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with valid/ready handshake.
// Holds a main register that drives EX_* and, when ID_EX_STAGE_SKID_EN is
// defined, a skid register so ID_ready can be registered (no combinational
// path from EX_ready). Without the macro the stage is a single register
// whose ID_ready is combinational. Flush zeroes the payload and drops all
// entries; reset overrides flush.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 26,
  parameter int unsigned REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              ID_valid,
  output logic              ID_ready,
  input  logic [DATA_W-1:0] ID_incrementedPC,
  input  logic [IMM_W-1:0]  ID_imm16,
  input  logic [DATA_W-1:0] ID_Aoperand,
  input  logic [DATA_W-1:0] ID_Boperand,
  input  logic [REG_W-1:0]  ID_rd2,
  output logic              EX_valid,
  input  logic              EX_ready,
  output logic [DATA_W-1:0] EX_incrementedPC,
  output logic [IMM_W-1:0]  EX_imm16,
  output logic [DATA_W-1:0] EX_Aoperand,
  output logic [DATA_W-1:0] EX_Boperand,
  output logic [REG_W-1:0]  EX_o_rd2,
  output logic [1:0]        o_occupancy
);

  localparam int unsigned PW = 3 * DATA_W + IMM_W + REG_W;

  logic [PW-1:0] w_in_data;
  logic [PW-1:0] r_main;
  logic          r_main_valid;
  logic          w_accept;
  logic          w_drain;
  logic          w_main_free;

  assign w_in_data = {ID_incrementedPC, ID_imm16, ID_Aoperand, ID_Boperand, ID_rd2};
  assign {EX_incrementedPC, EX_imm16, EX_Aoperand, EX_Boperand, EX_o_rd2} = r_main;
  assign EX_valid    = r_main_valid;

  assign w_accept    = ID_valid & ID_ready;
  assign w_drain     = r_main_valid & EX_ready;
  assign w_main_free = ~r_main_valid | w_drain;

`ifdef ID_EX_STAGE_SKID_EN

  logic [PW-1:0] r_skid;
  logic          r_skid_valid;

  // ID_ready depends only on state, so EX_ready never reaches it combinationally.
  assign ID_ready    = ~r_skid_valid;
  assign o_occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  // Main/skid update: skid refills main first to keep arrival order; an accept
  // while main is stalled parks the entry in skid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // ID_ready is low whenever skid is valid, so no accept can coincide here.
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_in_data;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_in_data;
      r_skid_valid <= 1'b1;
    end
  end

`else

  assign ID_ready    = w_main_free;
  assign o_occupancy = {1'b0, r_main_valid};

  // Single register: load on accept (possibly on the same edge as a drain).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_main_valid <= 1'b0;
      r_main       <= '0;
    end else if (w_accept) begin
      r_main       <= w_in_data;
      r_main_valid <= 1'b1;
    end else if (w_drain) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Accepted payloads are
// queued by a reference model of the handshake and compared in order as the
// DUT presents them on EX_*. Works in both buffering modes.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 26;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned PW     = 3 * DATA_W + IMM_W + REG_W;

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_flush = 1'b0;
  logic              ID_valid = 1'b0;
  logic              ID_ready;
  logic [DATA_W-1:0] ID_incrementedPC;
  logic [IMM_W-1:0]  ID_imm16;
  logic [DATA_W-1:0] ID_Aoperand;
  logic [DATA_W-1:0] ID_Boperand;
  logic [REG_W-1:0]  ID_rd2;
  logic              EX_valid;
  logic              EX_ready = 1'b0;
  logic [DATA_W-1:0] EX_incrementedPC;
  logic [IMM_W-1:0]  EX_imm16;
  logic [DATA_W-1:0] EX_Aoperand;
  logic [DATA_W-1:0] EX_Boperand;
  logic [REG_W-1:0]  EX_o_rd2;
  logic [1:0]        o_occupancy;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .IMM_W(IMM_W), .REG_W(REG_W)) dut (
    .i_clk            (clk),
    .i_rst_n          (i_rst_n),
    .i_flush          (i_flush),
    .ID_valid         (ID_valid),
    .ID_ready         (ID_ready),
    .ID_incrementedPC (ID_incrementedPC),
    .ID_imm16         (ID_imm16),
    .ID_Aoperand      (ID_Aoperand),
    .ID_Boperand      (ID_Boperand),
    .ID_rd2           (ID_rd2),
    .EX_valid         (EX_valid),
    .EX_ready         (EX_ready),
    .EX_incrementedPC (EX_incrementedPC),
    .EX_imm16         (EX_imm16),
    .EX_Aoperand      (EX_Aoperand),
    .EX_Boperand      (EX_Boperand),
    .EX_o_rd2         (EX_o_rd2),
    .o_occupancy      (o_occupancy)
  );

  logic [PW-1:0] ex_pl;
  logic [PW-1:0] in_pl;
  assign ex_pl = {EX_incrementedPC, EX_imm16, EX_Aoperand, EX_Boperand, EX_o_rd2};
  assign {ID_incrementedPC, ID_imm16, ID_Aoperand, ID_Boperand, ID_rd2} = in_pl;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [PW-1:0] m_q[$];
  bit            m_zero   = 1'b0;
  bit            chk_on   = 1'b0;
  int unsigned   seq      = 1;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_pl(input logic [DATA_W-1:0] pc, input logic [IMM_W-1:0] imm,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [REG_W-1:0] rd);
    in_pl = {pc, imm, a, b, rd};
  endtask

  task automatic rand_pl();
    set_pl(DATA_W'(seq * 4), IMM_W'($urandom), $urandom, $urandom, REG_W'($urandom));
    seq++;
  endtask

  // One clock: drive inputs, check outputs before the edge, advance the model.
  task automatic cyc(input logic rst_n, input logic fl, input logic v, input logic er);
    bit m_rdy;
    bit dr;
    bit ac;
    i_rst_n  = rst_n;
    i_flush  = fl;
    ID_valid = v;
    EX_ready = er;
    @(negedge clk);
`ifdef ID_EX_STAGE_SKID_EN
    m_rdy = (m_q.size() < 2);
`else
    m_rdy = (m_q.size() == 0) || er;
`endif
    if (chk_on) begin
      check_eq("id_ready", 256'(ID_ready), 256'(m_rdy));
      check_eq("ex_valid", 256'(EX_valid), 256'(m_q.size() > 0));
      check_eq("occupancy", 256'(o_occupancy), 256'(m_q.size()));
      if (m_q.size() > 0)
        check_eq("payload", 256'(ex_pl), 256'(m_q[0]));
      else if (m_zero)
        check_eq("zero_payload", 256'(ex_pl), 256'(0));
    end
    @(posedge clk);
    if (!rst_n || fl) begin
      m_q.delete();
      m_zero = 1'b1;
    end else begin
      dr = (m_q.size() > 0) && er;
      ac = v && m_rdy;
      if (dr) void'(m_q.pop_front());
      if (ac) begin
        m_q.push_back(in_pl);
        m_zero = 1'b0;
      end
    end
    chk_on = 1'b1;
    #1;
  endtask

  initial begin
    set_pl('0, '0, '0, '0, '0);
    // Reset with a valid input present: must not be captured.
    rand_pl();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Streaming, back to back.
    set_pl(32'h4, '0, 32'h1, 32'h2, 5'd1);  cyc(1'b1, 1'b0, 1'b1, 1'b1);
    set_pl(32'h8, '0, 32'h3, 32'h4, 5'd2);  cyc(1'b1, 1'b0, 1'b1, 1'b1);
    set_pl(32'hC, '0, 32'h5, 32'h6, 5'd3);  cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: two entries while EX stalls, then release.
    set_pl(32'h10, '0, 32'h11, 32'h0, 5'd4); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    set_pl(32'h14, '0, 32'h22, 32'h0, 5'd5); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Flush with held entries and a same-cycle input carrying rd2=7.
    rand_pl(); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rand_pl(); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    set_pl(32'h70, '0, 32'h77, 32'h77, 5'd7); cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Reset and flush on the same edge with held entries.
    rand_pl(); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rand_pl(); cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rand_pl(); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      rand_pl();
      cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
